// File: rtl/hybrid_subtractor8_pipe.sv
// Purpose : 8-bit subtractor (Xi - Yi - B0) with Di/B8/Z/N/V flags; low nibble carry-lookahead, high nibble ripple.
// Latency : 2 cycles from input acceptance to out_valid; one result per cycle sustained.
// Backpr. : valid/ready on both ports; in_ready = !s1_valid | !s2_valid | out_ready (combinational, no skid buffer).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake for Xi, Yi (8b) and B0 (borrow-in)
//   out_valid/out_ready result handshake for Di (8b), B8 (borrow-out), Z, N, V
module hybrid_subtractor8_pipe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] Xi,
   input  logic [7:0] Yi,
   input  logic       B0,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] Di,
   output logic       B8,
   output logic       Z,
   output logic       N,
   output logic       V
);

   // Stage-1 combinational lookahead on bits 3:0 of Xi + ~Yi with carry-in ~B0
   logic [3:0] w_ny_lo;
   logic [3:0] w_p;
   logic [3:0] w_g;
   logic [4:0] w_c;
   logic [3:0] w_d_lo;

   // Pipeline handshake
   logic       w_s1_ready;
   logic       w_s2_ready;

   // Stage-1 registers
   logic       r_s1_valid;
   logic [3:0] r_s1_p;
   logic [3:0] r_s1_g;
   logic [4:1] r_s1_c;
   logic [3:0] r_s1_d_lo;
   logic [3:0] r_s1_x_hi;
   logic [3:0] r_s1_ny_hi;
   logic       r_s1_x7;
   logic       r_s1_y7;

   // Stage-2 combinational ripple on bits 7:4
   logic [3:0] w_d_hi;
   logic       w_carry;
   logic       w_c8;
   logic [7:0] w_d;

   // Stage-2 (output) registers
   logic       r_s2_valid;
   logic [7:0] r_di;
   logic       r_b8;
   logic       r_z;
   logic       r_n;
   logic       r_v;

   assign w_ny_lo = ~Yi[3:0];
   assign w_p     = Xi[3:0] ^ w_ny_lo;
   assign w_g     = Xi[3:0] & w_ny_lo;

   // Subtraction as addition: carry-in is the inverted borrow-in
   assign w_c[0] = ~B0;
   assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign w_d_lo = w_p ^ w_c[3:0];

   // A stage may load when empty or when the stage after it frees up this cycle
   assign w_s2_ready = !r_s2_valid || out_ready;
   assign w_s1_ready = !r_s1_valid || w_s2_ready;
   assign in_ready   = w_s1_ready;

   always_comb begin
      w_d_hi  = '0;
      w_carry = r_s1_c[4];
      for (int i = 0; i < 4; i++) begin
         w_d_hi[i] = r_s1_x_hi[i] ^ r_s1_ny_hi[i] ^ w_carry;
         w_carry   = (r_s1_x_hi[i] & r_s1_ny_hi[i])
                   | (w_carry & (r_s1_x_hi[i] ^ r_s1_ny_hi[i]));
      end
      w_c8 = w_carry;
   end

   assign w_d = {w_d_hi, r_s1_d_lo};

   // P/G and the intermediate carries are kept registered for debug visibility;
   // stage 2 only needs the resolved C4.
   logic w_unused_dbg;
   assign w_unused_dbg = ^{r_s1_p, r_s1_g, r_s1_c[3:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_p     <= '0;
         r_s1_g     <= '0;
         r_s1_c     <= '0;
         r_s1_d_lo  <= '0;
         r_s1_x_hi  <= '0;
         r_s1_ny_hi <= '0;
         r_s1_x7    <= 1'b0;
         r_s1_y7    <= 1'b0;
         r_s2_valid <= 1'b0;
         r_di       <= '0;
         r_b8       <= 1'b0;
         r_z        <= 1'b0;
         r_n        <= 1'b0;
         r_v        <= 1'b0;
      end else begin
         if (w_s1_ready) begin
            r_s1_valid <= in_valid;
         end
         if (w_s1_ready && in_valid) begin
            r_s1_p     <= w_p;
            r_s1_g     <= w_g;
            r_s1_c     <= w_c[4:1];
            r_s1_d_lo  <= w_d_lo;
            r_s1_x_hi  <= Xi[7:4];
            r_s1_ny_hi <= ~Yi[7:4];
            r_s1_x7    <= Xi[7];
            r_s1_y7    <= Yi[7];
         end
         if (w_s2_ready) begin
            r_s2_valid <= r_s1_valid;
         end
         if (w_s2_ready && r_s1_valid) begin
            r_di <= w_d;
            r_b8 <= ~w_c8;  // no carry out of bit 7 means a borrow occurred
            r_z  <= (w_d == 8'h00);
            r_n  <= w_d[7];
            r_v  <= (r_s1_x7 != r_s1_y7) && (w_d[7] != r_s1_x7);
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign Di        = r_di;
   assign B8        = r_b8;
   assign Z         = r_z;
   assign N         = r_n;
   assign V         = r_v;

endmodule

// File: tb/tb_hybrid_subtractor8_pipe.sv
// Purpose : scoreboard bench for hybrid_subtractor8_pipe (directed vectors, backpressure, reset, random).
// Latency : expects results 2 cycles after acceptance when out_ready is held high.
// Backpr. : drives random out_ready; checks in_ready against pipeline occupancy.
module tb_hybrid_subtractor8_pipe;

   typedef struct packed {
      logic [7:0] d;
      logic       b8;
      logic       z;
      logic       n;
      logic       v;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] Xi = 8'h00;
   logic [7:0] Yi = 8'h00;
   logic       B0 = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] Di;
   logic       B8;
   logic       Z;
   logic       N;
   logic       V;

   res_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   hybrid_subtractor8_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Xi        (Xi),
      .Yi        (Yi),
      .B0        (B0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Di        (Di),
      .B8        (B8),
      .Z         (Z),
      .N         (N),
      .V         (V)
   );

   // Reference: plain integer arithmetic, unsigned and signed views
   function automatic res_t model(input logic [7:0] x, input logic [7:0] y, input logic b);
      res_t r;
      int   ud;
      int   sd;
      ud   = int'(x) - int'(y) - int'(b);
      sd   = int'($signed(x)) - int'($signed(y)) - int'(b);
      r.d  = ud[7:0];
      r.b8 = (ud < 0);
      r.z  = (r.d == 8'h00);
      r.n  = (r.d >= 8'h80);
      r.v  = (sd < -128) || (sd > 127);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented result must match the queue head; pop only on transfer
   always @(negedge clk) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
         end else begin
            chk("result{Di,B8,Z,N,V}", 32'({Di, B8, Z, N, V}), 32'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   // One clock of stimulus; ev >= 0 checks out_valid right after the edge
   task automatic cycle(input logic iv, input logic [7:0] x, input logic [7:0] y,
                        input logic b, input logic ordy, input int ev, output logic acc);
      @(posedge clk);
      #1;
      if (ev >= 0) chk("out_valid_timing", 32'(out_valid), 32'(ev));
      in_valid  = iv;
      Xi        = x;
      Yi        = y;
      B0        = b;
      out_ready = ordy;
      #1;
      chk("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || ordy));
      @(negedge clk);
      #1;
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(model(x, y, b));
   endtask

   logic [7:0] dx[4] = '{8'h50, 8'h00, 8'h80, 8'h3C};
   logic [7:0] dy[4] = '{8'h20, 8'h01, 8'h01, 8'h3C};
   logic       db[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
   res_t       dexp[4];

   initial begin
      logic acc;
      int   idx;

      // Reset state, checked while reset is held
      #12;
      chk("reset_outputs", 32'({out_valid, Di, B8, Z, N, V}), 32'd0);
      #5 rst_n = 1'b1;
      #1 chk("in_ready_after_reset", 32'(in_ready), 32'd1);

      // Directed vectors, each checked for 2-cycle latency and value
      dexp[0] = '{d: 8'h30, b8: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0};
      dexp[1] = '{d: 8'hFE, b8: 1'b1, z: 1'b0, n: 1'b1, v: 1'b0};
      dexp[2] = '{d: 8'h7F, b8: 1'b0, z: 1'b0, n: 1'b0, v: 1'b1};
      dexp[3] = '{d: 8'h00, b8: 1'b0, z: 1'b1, n: 1'b0, v: 1'b0};
      for (int i = 0; i < 4; i++) begin
         chk("model_vs_table", 32'(model(dx[i], dy[i], db[i])), 32'(dexp[i]));
         cycle(1'b1, dx[i], dy[i], db[i], 1'b1, -1, acc);
         cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 0, acc);
         cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1, acc);
      end

      // Backpressure: 4 operands, out_ready low for 3 cycles from first out_valid
      idx = 0;
      for (int c = 0; c < 30 && (idx < 4 || exp_q.size() > 0); c++) begin
         cycle(idx < 4, 8'(8'h11 * (idx + 1)), 8'(8'h23 * idx), 1'(idx), !(c >= 2 && c <= 4),
               (c == 2) ? 1 : -1, acc);
         if (acc) idx++;
      end
      chk("bp_all_accepted", 32'(idx), 32'd4);
      chk("bp_all_drained", 32'(exp_q.size()), 32'd0);

      // Reset with both stages full
      cycle(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, -1, acc);
      cycle(1'b1, 8'h56, 8'h07, 1'b1, 1'b0, -1, acc);
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1, acc);
      #1 rst_n = 1'b0;
      #1 chk("midstream_reset_clear", 32'({out_valid, Di, B8, Z, N, V}), 32'd0);
      exp_q.delete();
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 0, acc);
      cycle(1'b1, 8'h9A, 8'hC3, 1'b1, 1'b1, 0, acc);
      chk("post_reset_accept", 32'(acc), 32'd1);
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 0, acc);
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1, acc);

      // Random regression with random valid/ready toggling
      for (int i = 0; i < 10000; i++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) != 0), -1, acc);
      end
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
         cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, -1, acc);
      end
      chk("final_drain", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
